mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-port memory arbiter. It multiplexes requesters (CPU, GPU, VRAM/DMA clients) onto one backing memory port, for example the DDR3 front-end or on-chip RAM. Each port uses a req/ack handshake. One transaction is in flight at a time. Arbitration is round-robin or fixed-priority, chosen by parameter.

Parameters:
NUM_PORTS, 3, number of requester ports (2..8)
ADDR_W, 10, word address width
DATA_W, 32, data width
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
IDX_W, $clog2(NUM_PORTS), winner index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
port_req  in  NUM_PORTS  request per port; held until matching ack
port_we  in  NUM_PORTS  1 = write, 0 = read
port_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port i at [i*ADDR_W +: ADDR_W]
port_wdata  in  NUM_PORTS*DATA_W  flattened write data
port_ack  out  NUM_PORTS  one-cycle completion pulse, one-hot
port_rdata  out  DATA_W  read data; valid in the ack cycle of a read
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid; at least 1 cycle after acceptance
mem_rdata  in  DATA_W  read data
busy  out  1  high in any state except IDLE
gnt_id  out  IDX_W  index of the current or last winner
err  out  1  sticky protocol error flag

Behaviour:
- Reset values (rst=0 at a clk edge): state IDLE; port_ack=0; port_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; busy=0; gnt_id=0; err=0; RR pointer last=NUM_PORTS-1, so port 0 wins first.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: if any port_req is set, select a winner and latch its index, we, addr and wdata into the mem_* registers. Set mem_req=1 and go to ISSUE. If no request, stay in IDLE.
- Round-robin selection: the first requester scanning from last+1 upward, wrapping modulo NUM_PORTS. On selection, last := winner.
- Fixed-priority selection: the lowest requesting index. The RR pointer is unused.
- ISSUE: mem_* are held stable while mem_ready=0, with no timeout. On mem_ready=1:
  - mem_req := 0.
  - Write: go to DONE.
  - Read: go to WAIT_RD.
- WAIT_RD: on mem_rvalid=1, port_rdata := mem_rdata and go to DONE.
- DONE: port_ack[gnt_id]=1 for exactly one cycle, then IDLE. port_rdata holds its value until the next read completes.
- Requester rule: drop req, or present a new request, on the edge where ack is sampled. The arbiter next samples port_req one cycle after DONE, so there is no double-service.
- Latency with mem_ready=1 and mem_rvalid 1 cycle after accept:
  - Write: req sampled at edge E0, ack high in cycle E2..E3.
  - Read: ack high in cycle E3..E4.
  - Back-to-back throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- Inputs of non-winning ports are ignored. Changes to the winner's port_addr/we/wdata after the IDLE sample are ignored, because the values are latched.
- Simultaneous requests: exactly one winner per arbitration; the others wait.
  - Round-robin: any continuously asserted req is served within NUM_PORTS arbitrations.
- err is sticky until reset. It is set when mem_rvalid=1 in any state other than WAIT_RD, including a late response after reset. A stray mem_rvalid never changes state or port_rdata.
- mem_ready while mem_req=0 is ignored.
- Reset mid-transaction: the transaction is abandoned, mem_req drops at that edge, and no ack is issued. The backing memory shares rst.

Test Plan:
- Reset with stray stimulus: hold rst=0 for 3 cycles with port_req=3'b111 → all outputs 0, busy=0. After release, the first grant is gnt_id=0.
- Single write: port 1 writes addr 0x2A, data 0xDEADBEEF, mem_ready=1 → mem_req high one cycle with mem_addr=0x2A, mem_we=1. port_ack=3'b010 two cycles after the req is sampled. err=0.
- Read with stall: port 2 reads addr 0x155; mem_ready low for 4 cycles, then rvalid 3 cycles after accept with 0x12345678 → mem_* stable throughout, port_ack=3'b100, port_rdata=0x12345678.
- Round-robin fairness: all 3 ports request reads continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2. With PRIORITY_MODE=1 → port 0 only, until it drops req.
- Wrap with NUM_PORTS=4: last=3 and ports 0 and 3 requesting → port 0 wins, then port 3.
- Errors and reset: mem_rvalid pulse while IDLE → err=1, state unchanged. Reset asserted in WAIT_RD → no ack; err cleared to 0. A later stray rvalid sets err=1 again.

Source files
------------

// File: rtl/mem_arbiter.sv
// N-port req/ack arbiter multiplexing requesters onto a single memory port,
// one transaction in flight, round-robin or fixed-priority selection.
module mem_arbiter #(
  parameter int NUM_PORTS     = 3,
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int PRIORITY_MODE = 0,
  localparam int IDX_W        = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_ack,
  output logic [DATA_W-1:0]           port_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [IDX_W-1:0]            gnt_id,
  output logic                        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win, win_hi, win_lo;
  logic               found_hi, found_lo;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Downward scans leave the lowest matching index as the final assignment.
  // Round-robin prefers the lowest requester above last, else wraps to the lowest overall.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_req[i]) begin
        if (PRIORITY_MODE == 0 && i > int'(last)) begin
          win_hi   = IDX_W'(i);
          found_hi = 1'b1;
        end else begin
          win_lo   = IDX_W'(i);
          found_lo = 1'b1;
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == win) begin
        sel_we    = port_we[i];
        sel_addr  = port_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = port_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= IDX_W'(NUM_PORTS - 1);
      port_ack   <= '0;
      port_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      gnt_id     <= '0;
      err        <= 1'b0;
    end else begin
      port_ack <= '0;
      // A response outside WAIT_RD is flagged but otherwise has no effect.
      if (mem_rvalid && state != WAIT_RD) err <= 1'b1;

      case (state)
        IDLE: begin
          if (found_hi || found_lo) begin
            gnt_id    <= win;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
            if (PRIORITY_MODE == 0) last <= win;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= mem_we ? DONE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (mem_rvalid) begin
            port_rdata <= mem_rdata;
            state      <= DONE;
          end
        end
        DONE: begin
          port_ack <= NUM_PORTS'(1) << gnt_id;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single transactions plus
// hand-written reset, fairness, stall, error and wrap-around sequences.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---- 3-port round-robin DUT and fixed-priority DUT share requesters ----
  logic [2:0]    port_req, port_we;
  logic [3*AW-1:0] port_addr;
  logic [3*DW-1:0] port_wdata;

  logic [2:0]    port_ack;
  logic [DW-1:0] port_rdata, mem_wdata, mem_rdata, man_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_req, mem_we, mem_ready, mem_rvalid, busy, err;
  logic [1:0]    gnt_id;
  logic          auto_mode, man_ready, man_rvalid;
  logic          auto_rv = 1'b0;
  logic [AW-1:0] auto_addr = '0;

  logic [2:0]    f_ack;
  logic [DW-1:0] f_rdata, f_mem_wdata;
  logic [AW-1:0] f_mem_addr;
  logic          f_mem_req, f_mem_we, f_busy, f_err;
  logic [1:0]    f_gnt;
  logic          f_rv = 1'b0;
  logic [AW-1:0] f_raddr = '0;

  // ---- 4-port round-robin DUT for the wrap-around case ----
  logic [3:0]    q_req, q_we, q_ack;
  logic [4*AW-1:0] q_addr;
  logic [4*DW-1:0] q_wdata;
  logic [DW-1:0] q_rdata, q_mem_wdata;
  logic [AW-1:0] q_mem_addr;
  logic          q_mem_req, q_mem_we, q_busy, q_err;
  logic [1:0]    q_gnt;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'h0, a};
  endfunction

  // Memory model: always ready, read data one cycle after acceptance.
  always @(posedge clk) begin
    auto_rv   <= mem_req && mem_ready && !mem_we;
    auto_addr <= mem_addr;
    f_rv      <= f_mem_req && !f_mem_we;
    f_raddr   <= f_mem_addr;
  end

  assign mem_ready  = auto_mode ? 1'b1 : man_ready;
  assign mem_rvalid = auto_mode ? auto_rv : man_rvalid;
  assign mem_rdata  = auto_mode ? mem_model(auto_addr) : man_rdata;

  mem_arbiter #(.NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ack(port_ack), .port_rdata(port_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .gnt_id(gnt_id), .err(err)
  );

  mem_arbiter #(.NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ack(f_ack), .port_rdata(f_rdata),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_ready(1'b1), .mem_rvalid(f_rv), .mem_rdata(mem_model(f_raddr)),
    .busy(f_busy), .gnt_id(f_gnt), .err(f_err)
  );

  mem_arbiter #(.NUM_PORTS(4), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0)) dut4 (
    .clk(clk), .rst(rst),
    .port_req(q_req), .port_we(q_we), .port_addr(q_addr), .port_wdata(q_wdata),
    .port_ack(q_ack), .port_rdata(q_rdata),
    .mem_req(q_mem_req), .mem_we(q_mem_we), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
    .mem_ready(1'b1), .mem_rvalid(1'b0), .mem_rdata(32'h0),
    .busy(q_busy), .gnt_id(q_gnt), .err(q_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name, input int budget);
    n_checks++;
    $display("FAIL %s: no ack within %0d cycles", name, budget);
  endtask

  task automatic wait_ack(input string name, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (port_ack == 3'b000 && cycles < budget);
    if (port_ack == 3'b000) timeout(name, budget);
  endtask

  task automatic wait_q(input string name, input int budget);
    int cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (q_ack == 4'b0000 && cycles < budget);
    if (q_ack == 4'b0000) timeout(name, budget);
  endtask

  typedef struct {
    logic [1:0]    port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    exp_ack;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  // One isolated transaction: latched mem_* values, ack vector, latency, read data.
  task automatic run_vec(input vec_t v, input int n);
    int    cyc;
    string tag;
    tag = $sformatf("vec%0d", n);
    @(negedge clk);
    port_req                     = 3'b000;
    port_req[v.port]             = 1'b1;
    port_we[v.port]              = v.we;
    port_addr[v.port*AW +: AW]   = v.addr;
    port_wdata[v.port*DW +: DW]  = v.wdata;
    @(negedge clk);
    check({tag, "_mem_req"},  mem_req, 1'b1);
    check({tag, "_mem_addr"}, mem_addr, v.addr);
    check({tag, "_mem_we"},   mem_we, v.we);
    check({tag, "_gnt_id"},   gnt_id, v.port);
    if (v.we) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
    // Changes after the grant must not reach the memory side.
    port_addr[v.port*AW +: AW]  = ~v.addr;
    port_wdata[v.port*DW +: DW] = ~v.wdata;
    cyc = 1;
    while (port_ack == 3'b000 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (port_ack == 3'b000) timeout(tag, 10);
    check({tag, "_ack"},     port_ack, v.exp_ack);
    check({tag, "_latency"}, cyc, v.exp_lat);
    check({tag, "_rdata"},   port_rdata, v.exp_rdata);
    check({tag, "_err"},     err, 1'b0);
    port_req = 3'b000;
    @(negedge clk);
    check({tag, "_ack_1cyc"}, {port_ack, busy}, 4'b0000);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic [2:0] ack_seen;

    vecs[0] = '{2'd1, 1'b1, 10'h02A, 32'hDEADBEEF, 3'b010, 32'hC0DE0101, 3};
    vecs[1] = '{2'd0, 1'b0, 10'h001, 32'h0,        3'b001, 32'hC0DE0001, 4};
    vecs[2] = '{2'd2, 1'b0, 10'h3FF, 32'h0,        3'b100, 32'hC0DE03FF, 4};
    vecs[3] = '{2'd2, 1'b1, 10'h155, 32'h00000000, 3'b100, 32'hC0DE03FF, 3};
    vecs[4] = '{2'd0, 1'b1, 10'h000, 32'hFFFFFFFF, 3'b001, 32'hC0DE03FF, 3};
    vecs[5] = '{2'd1, 1'b0, 10'h000, 32'h0,        3'b010, 32'hC0DE0000, 4};

    auto_mode  = 1'b1;
    man_ready  = 1'b0;
    man_rvalid = 1'b0;
    man_rdata  = '0;
    port_req   = 3'b111;
    port_we    = 3'b000;
    port_addr  = {10'h102, 10'h101, 10'h100};
    port_wdata = '0;
    q_req      = 4'b0000;
    q_we       = 4'b1111;
    q_addr     = {10'h333, 10'h222, 10'h111, 10'h000};
    q_wdata    = '0;

    // Reset with requests asserted: everything held at zero.
    repeat (3) @(negedge clk);
    check("rst_ctrl",   {port_ack, mem_req, mem_we, busy, err, gnt_id}, 9'h000);
    check("rst_rdata",  port_rdata, 32'h0);
    check("rst_addr",   mem_addr, 10'h0);
    check("rst_wdata",  mem_wdata, 32'h0);

    // Release with all three requesting: port 0 wins first, then strict rotation.
    rst = 1'b1;
    @(negedge clk);
    check("first_gnt",    gnt_id, 2'd0);
    check("first_req",    {mem_req, busy}, 2'b11);
    check("fp_first_gnt", f_gnt, 2'd0);
    for (int k = 0; k < 9; k++) begin
      wait_ack("rr_wait", 8, cyc);
      check($sformatf("rr_order_%0d", k), port_ack, 3'b001 << (k % 3));
      check($sformatf("fp_only0_%0d", k), f_ack, 3'b001);
    end
    // Port 0 drops out: fixed priority moves to port 1, round-robin continues to port 1.
    port_req = 3'b110;
    wait_ack("drop0_wait", 8, cyc);
    check("rr_after_drop", port_ack, 3'b010);
    check("fp_after_drop", f_ack, 3'b010);
    port_req = 3'b000;
    check("rr_err", err, 1'b0);

    // Isolated transactions from the vector table.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Read with a 4-cycle ready stall and rvalid 3 cycles after acceptance.
    auto_mode = 1'b0;
    @(negedge clk);
    port_req          = 3'b100;
    port_we[2]        = 1'b0;
    port_addr[20 +: AW] = 10'h155;
    @(negedge clk);
    check("stall_gnt", gnt_id, 2'd2);
    port_addr[20 +: AW] = 10'h0AA;
    port_we[2]          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_hold_%0d", i), {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 10'h155});
      if (i < 3) @(negedge clk);
    end
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    check("stall_accept", {mem_req, busy}, 2'b01);
    @(negedge clk);
    check("stall_noack_a", port_ack, 3'b000);
    @(negedge clk);
    check("stall_noack_b", port_ack, 3'b000);
    man_rvalid = 1'b1;
    man_rdata  = 32'h12345678;
    @(negedge clk);
    man_rvalid = 1'b0;
    man_rdata  = 32'hFFFF0000;
    wait_ack("stall_wait", 4, cyc);
    check("stall_ack",   port_ack, 3'b100);
    check("stall_rdata", port_rdata, 32'h12345678);
    check("stall_err",   err, 1'b0);
    port_req = 3'b000;

    // mem_ready without a pending request is ignored.
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
    check("idle_ready", {mem_req, busy, port_ack}, 5'b00000);

    // Stray rvalid while idle: sticky err, no state or data change.
    man_rvalid = 1'b1;
    man_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    man_rvalid = 1'b0;
    check("stray_err",   err, 1'b1);
    check("stray_busy",  busy, 1'b0);
    check("stray_rdata", port_rdata, 32'h12345678);

    // Reset while waiting for read data: transaction abandoned, err cleared.
    port_req          = 3'b001;
    port_we[0]        = 1'b0;
    port_addr[0 +: AW] = 10'h077;
    man_ready         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    man_ready = 1'b0;
    check("wrd_state", {busy, mem_req}, 2'b10);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outs",  {mem_req, busy, err, port_ack}, 6'b000000);
    check("midrst_rdata", port_rdata, 32'h0);
    rst      = 1'b1;
    port_req = 3'b000;
    ack_seen = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seen = ack_seen | port_ack;
    end
    check("midrst_no_ack", ack_seen, 3'b000);
    man_rvalid = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b0;
    check("late_rvalid_err", err, 1'b1);

    // 4-port wrap-around: after port 3 is served, ports 0 and 3 -> 0 then 3.
    q_req = 4'b1000;
    wait_q("q_first", 8);
    check("q_first_ack", {q_ack, q_gnt}, {4'b1000, 2'd3});
    q_req = 4'b0000;
    @(negedge clk);
    q_req = 4'b1001;
    wait_q("q_wrap", 8);
    check("q_wrap_ack", {q_ack, q_gnt}, {4'b0001, 2'd0});
    q_req = 4'b1000;
    wait_q("q_next", 8);
    check("q_next_ack", {q_ack, q_gnt}, {4'b1000, 2'd3});
    q_req = 4'b0000;
    check("q_err", q_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
